// File: rtl/alu_result_reg_32bit.sv
// ---------------------------------------------------------------------------
// alu_result_reg_32bit
//
// Purpose:
//    Two-entry registered result buffer placed directly after the ALU function
//    units. Each accepted 32-bit result is stored with its carry, and the
//    zero/negative flags are derived at capture time. Results leave in FIFO
//    order through a valid/ready handshake towards writeback. The buffer
//    breaks the combinational ALU path from writeback timing and can absorb a
//    single cycle of writeback stall without losing a result.
//
// Ports:
//    clk        in   1   rising-edge clock
//    rst_n      in   1   synchronous, active-low reset
//    IN_VALID   in   1   Z/C carry a valid ALU result this cycle
//    IN_READY   out  1   buffer can accept a result this cycle
//    Z          in  32   ALU result
//    C          in   1   carry-out belonging to Z
//    OUT_VALID  out  1   head entry holds a valid result
//    OUT_READY  in   1   writeback consumes the head entry this cycle
//    R          out 32   head entry result (0 when empty)
//    FLAGS      out  3   head entry flags {carry, negative, zero} (0 when empty)
//    COUNT      out  2   occupancy, 0..2
// ---------------------------------------------------------------------------
module alu_result_reg_32bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] Z,
   input  logic        C,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] R,
   output logic [2:0]  FLAGS,
   output logic [1:0]  COUNT
);

   // Occupancy state; the encoding equals the entry count so COUNT is a
   // direct copy of the state register.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   occ_state_t  r_state;
   occ_state_t  w_state_next;

   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [31:0] r_data  [0:1];
   logic [2:0]  r_flags [0:1];

   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_flags_in;

   // ------------------------------------------------------------------------
   // Handshake decode. IN_READY depends only on registered occupancy and
   // rst_n, so there is no combinational path from OUT_READY to IN_READY.
   // ------------------------------------------------------------------------
   assign IN_READY  = rst_n & (r_state != ST_FULL);
   assign OUT_VALID = (r_state != ST_EMPTY);
   assign COUNT     = r_state;

   assign w_push = IN_VALID  & IN_READY;
   assign w_pop  = OUT_VALID & OUT_READY;

   // Flags captured alongside the data: {carry, negative, zero}.
   assign w_flags_in = {C, Z[31], (Z == 32'h0000_0000)};

   // ------------------------------------------------------------------------
   // Occupancy FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Occupancy FSM: next-state logic. Push is impossible when FULL and pop is
   // impossible when EMPTY because the handshake decode already masks them.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            // push & pop together keeps one entry: the new result becomes
            // the head as the old head retires.
            if (w_push && !w_pop) begin
               w_state_next = ST_FULL;
            end else if (!w_push && w_pop) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_next = ST_ONE;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Pointers. Single-bit pointers wrap 1 -> 0 naturally by inversion.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Entry storage. Entries are cleared on reset so stale results can never
   // resurface on R after a mid-stream reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i]  <= 32'h0000_0000;
            r_flags[i] <= 3'b000;
         end
      end else if (w_push) begin
         r_data[r_wr_ptr]  <= Z;
         r_flags[r_wr_ptr] <= w_flags_in;
      end
   end

   // ------------------------------------------------------------------------
   // Head presentation: forced to zero when the buffer is empty. There is no
   // bypass from Z, so a result is visible one cycle after it is accepted.
   // ------------------------------------------------------------------------
   always_comb begin
      R     = 32'h0000_0000;
      FLAGS = 3'b000;
      if (OUT_VALID) begin
         R     = r_data[r_rd_ptr];
         FLAGS = r_flags[r_rd_ptr];
      end
   end

endmodule

// File: tb/tb_alu_result_reg_32bit.sv
module tb_alu_result_reg_32bit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] z;
   logic        c;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] r;
   logic [2:0]  flags;
   logic [1:0]  count;

   int errors = 0;
   int checks = 0;

   alu_result_reg_32bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .Z         (z),
      .C         (c),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .R         (r),
      .FLAGS     (flags),
      .COUNT     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain queue of {carry, negative, zero, data} records.
   logic [34:0] mq[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check IN_READY before the edge, advance
   // the model at the edge, then compare the registered outputs after it.
   task automatic cycle(input logic rn, input logic iv, input logic [31:0] zz,
                        input logic cc, input logic ordy);
      logic        exp_ready;
      logic [34:0] e;
      rst_n     = rn;
      in_valid  = iv;
      z         = zz;
      c         = cc;
      out_ready = ordy;
      exp_ready = rn && (mq.size() < 2);
      @(negedge clk);
      chk("in_ready_pre", 32'(in_ready), 32'(exp_ready));
      @(posedge clk);
      if (!rn) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (iv && exp_ready) mq.push_back({cc, zz[31], zz == 32'h0, zz});
      end
      #1;
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      e = (mq.size() != 0) ? mq[0] : 35'h0;
      chk("model_r", r, e[31:0]);
      chk("model_flags", 32'(flags), 32'(e[34:32]));
   endtask

   typedef struct {
      string       name;
      logic        rn;
      logic        iv;
      logic [31:0] zz;
      logic        cc;
      logic        ordy;
      logic [1:0]  e_count;
      logic [31:0] e_r;
      logic [2:0]  e_flags;
      logic        e_ready;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; z = '0; c = 1'b0; out_ready = 1'b0;

      // name, rst_n, in_valid, Z, C, OUT_READY | COUNT, R, FLAGS, IN_READY after edge
      vecs.push_back('{"rst_push_a",  0, 1, 32'h0000_1234, 1, 0, 0, 32'h0,         3'b000, 0});
      vecs.push_back('{"rst_push_b",  0, 1, 32'h0000_0055, 0, 1, 0, 32'h0,         3'b000, 0});
      vecs.push_back('{"release",     1, 0, 32'h0,         0, 0, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"single",      1, 1, 32'hFFFF_FFF0, 0, 0, 1, 32'hFFFF_FFF0, 3'b010, 1});
      vecs.push_back('{"single_pop",  1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"flag_zc",     1, 1, 32'h0000_0000, 1, 0, 1, 32'h0,         3'b101, 1});
      vecs.push_back('{"flag_zc_pop", 1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"flag_neg",    1, 1, 32'h8000_0000, 0, 0, 1, 32'h8000_0000, 3'b010, 1});
      vecs.push_back('{"flag_negpop", 1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"bp_push11",   1, 1, 32'h0000_0011, 0, 0, 1, 32'h11,        3'b000, 1});
      vecs.push_back('{"bp_push22",   1, 1, 32'h0000_0022, 0, 0, 2, 32'h11,        3'b000, 0});
      vecs.push_back('{"bp_hold33",   1, 1, 32'h0000_0033, 0, 0, 2, 32'h11,        3'b000, 0});
      vecs.push_back('{"bp_drain1",   1, 1, 32'h0000_0033, 0, 1, 1, 32'h22,        3'b000, 1});
      vecs.push_back('{"bp_drain2",   1, 1, 32'h0000_0033, 0, 1, 1, 32'h33,        3'b000, 1});
      vecs.push_back('{"bp_drain3",   1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"sim_headA",   1, 1, 32'h0000_000A, 0, 0, 1, 32'hA,         3'b000, 1});
      vecs.push_back('{"sim_pushB",   1, 1, 32'h0000_000B, 0, 1, 1, 32'hB,         3'b000, 1});
      vecs.push_back('{"sim_drain",   1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"mid_push5",   1, 1, 32'h0000_0005, 0, 0, 1, 32'h5,         3'b000, 1});
      vecs.push_back('{"mid_push6",   1, 1, 32'h0000_0006, 0, 0, 2, 32'h5,         3'b000, 0});
      vecs.push_back('{"mid_reset",   0, 1, 32'h0000_0007, 0, 1, 0, 32'h0,         3'b000, 0});
      vecs.push_back('{"mid_after1",  1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});
      vecs.push_back('{"mid_after2",  1, 0, 32'h0,         0, 1, 0, 32'h0,         3'b000, 1});

      @(posedge clk); #1;

      foreach (vecs[i]) begin
         cycle(vecs[i].rn, vecs[i].iv, vecs[i].zz, vecs[i].cc, vecs[i].ordy);
         chk({vecs[i].name, "_count"},     32'(count),     32'(vecs[i].e_count));
         chk({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'(vecs[i].e_count != 0));
         chk({vecs[i].name, "_r"},         r,              vecs[i].e_r);
         chk({vecs[i].name, "_flags"},     32'(flags),     32'(vecs[i].e_flags));
         chk({vecs[i].name, "_in_ready"},  32'(in_ready),  32'(vecs[i].e_ready));
         $display("vec %0d %s: count=%0d R=%h FLAGS=%b IN_READY=%b", i, vecs[i].name,
                  count, r, flags, in_ready);
      end

      // Streaming: 100 random values with OUT_READY held high. Each value
      // must appear at R exactly one cycle after it was offered.
      begin
         logic [31:0] prev;
         for (int i = 0; i < 100; i++) begin
            logic [31:0] v;
            v = $urandom;
            cycle(1'b1, 1'b1, v, 1'($urandom_range(0, 1)), 1'b1);
            chk("stream_r", r, v);
            if (i > 0) chk("stream_count", 32'(count), 32'd1);
            $display("stream %0d: Z=%h R=%h count=%0d", i, v, r, count);
            prev = v;
         end
         cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
         chk("stream_drained", 32'(count), 32'd0);
      end

      // Random traffic with random backpressure and occasional resets.
      for (int i = 0; i < 300; i++) begin
         logic        rn;
         logic [31:0] v;
         rn = ($urandom_range(0, 39) != 0);
         case ($urandom_range(0, 3))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000 | $urandom;
            default: v = $urandom;
         endcase
         cycle(rn, 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) != 0));
         $display("rand %0d: rst_n=%b count=%0d R=%h FLAGS=%b", i, rn, count, r, flags);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
